// File: rtl/stall_ctrl_pkg.sv
// Shared widths, parameter defaults and FSM encoding for the pipeline stall controller.
package stall_ctrl_pkg;

  localparam int REG_ADDR_W     = 5;
  localparam int MUL_CYCLES_DEF = 3;
  localparam int DIV_CYCLES_DEF = 32;
  localparam int MD_CNT_W       = 6;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_RUN  = 1'b1
  } md_state_e;

  // Remaining-cycle count carried by the issuing cycle; 1..64 maps onto 0..63.
  function automatic logic [MD_CNT_W-1:0] md_first_cnt(input int cycles);
    return MD_CNT_W'(cycles - 1);
  endfunction

endpackage

// File: rtl/stall_ctrl_hazard_detect.sv
// Load-use comparator: a load in EX whose destination feeds a source actually read in ID.
module hazard_detect
  import stall_ctrl_pkg::*;
(
  input  logic [REG_ADDR_W-1:0] raddr_1_i,
  input  logic [REG_ADDR_W-1:0] raddr_2_i,
  input  logic                  re_1_i,
  input  logic                  re_2_i,
  input  logic                  read_mem_i,
  input  logic [REG_ADDR_W-1:0] waddr_i,
  output logic                  load_use_o
);

  // Register 0 is hard-wired, so a load targeting it never creates a dependency.
  assign load_use_o = read_mem_i && (waddr_i != '0) &&
                      ((re_1_i && (raddr_1_i == waddr_i)) ||
                       (re_2_i && (raddr_2_i == waddr_i)));

endmodule

// File: rtl/stall_ctrl.sv
// Pipeline hold/bubble/flush generation: memory stall, multi-cycle mul/div, load-use and branch flush.
module stall_ctrl
  import stall_ctrl_pkg::*;
#(
  parameter int MUL_CYCLES = MUL_CYCLES_DEF,
  parameter int DIV_CYCLES = DIV_CYCLES_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] raddr_1_ID,
  input  logic [REG_ADDR_W-1:0] raddr_2_ID,
  input  logic                  re_1_ID,
  input  logic                  re_2_ID,
  input  logic                  ReadMem_EX,
  input  logic [REG_ADDR_W-1:0] waddr_EX,
  input  logic                  md_start_EX,
  input  logic                  md_is_div_EX,
  input  logic                  branch_taken_ID,
  input  logic                  mem_busy_MEM,
  output logic                  hold_PC,
  output logic                  hold_IF_ID,
  output logic                  hold_ID_EX,
  output logic                  hold_EX_MEM,
  output logic                  flush_IF_ID,
  output logic                  bubble_ID_EX,
  output logic                  bubble_EX_MEM,
  output logic                  bubble_MEM_WB,
  output logic                  md_busy,
  output logic                  md_done
);

  localparam logic [MD_CNT_W-1:0] MUL_FIRST = md_first_cnt(MUL_CYCLES);
  localparam logic [MD_CNT_W-1:0] DIV_FIRST = md_first_cnt(DIV_CYCLES);

  md_state_e           state_q, state_d;
  logic [MD_CNT_W-1:0] md_cnt_q, md_cnt_d;
  logic                flush_pend_q, flush_pend_d;

  logic                load_use;
  logic                issuing;
  logic                md_active;
  logic                md_last;
  logic [MD_CNT_W-1:0] cnt_cur;

  hazard_detect u_hazard_detect (
    .raddr_1_i  (raddr_1_ID),
    .raddr_2_i  (raddr_2_ID),
    .re_1_i     (re_1_ID),
    .re_2_i     (re_2_ID),
    .read_mem_i (ReadMem_EX),
    .waddr_i    (waddr_EX),
    .load_use_o (load_use)
  );

  // The issuing cycle already counts as stall cycle one, so it carries N-1 and the
  // register only ever sees N-2 downwards; N=1 finishes without entering MD_RUN.
  assign issuing   = (state_q == MD_IDLE) && md_start_EX && !mem_busy_MEM;
  assign cnt_cur   = issuing ? (md_is_div_EX ? DIV_FIRST : MUL_FIRST) : md_cnt_q;
  assign md_active = issuing || (state_q == MD_RUN);
  assign md_last   = md_active && (cnt_cur == '0);

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    state_d       = state_q;
    md_cnt_d      = md_cnt_q;
    flush_pend_d  = flush_pend_q;
    hold_PC       = 1'b0;
    hold_IF_ID    = 1'b0;
    hold_ID_EX    = 1'b0;
    hold_EX_MEM   = 1'b0;
    flush_IF_ID   = 1'b0;
    bubble_ID_EX  = 1'b0;
    bubble_EX_MEM = 1'b0;
    bubble_MEM_WB = 1'b0;
    md_done       = 1'b0;
    md_busy       = (state_q == MD_RUN) || issuing;

    if (mem_busy_MEM) begin
      hold_PC       = 1'b1;
      hold_IF_ID    = 1'b1;
      hold_ID_EX    = 1'b1;
      hold_EX_MEM   = 1'b1;
      bubble_MEM_WB = 1'b1;
    end else if (md_active) begin
      hold_PC       = 1'b1;
      hold_IF_ID    = 1'b1;
      hold_ID_EX    = 1'b1;
      bubble_EX_MEM = 1'b1;
      md_done       = md_last;
      if (md_last) begin
        state_d  = MD_IDLE;
        md_cnt_d = '0;
      end else begin
        state_d  = MD_RUN;
        md_cnt_d = cnt_cur - MD_CNT_W'(1);
      end
    end else if (load_use) begin
      hold_PC      = 1'b1;
      hold_IF_ID   = 1'b1;
      bubble_ID_EX = 1'b1;
    end

    // A branch seen while IF/ID is frozen is remembered and applied once it moves.
    if (!hold_IF_ID) begin
      flush_IF_ID  = branch_taken_ID || flush_pend_q;
      flush_pend_d = 1'b0;
    end else begin
      flush_pend_d = flush_pend_q || branch_taken_ID;
    end

    if (rst) begin
      hold_PC       = 1'b0;
      hold_IF_ID    = 1'b0;
      hold_ID_EX    = 1'b0;
      hold_EX_MEM   = 1'b0;
      flush_IF_ID   = 1'b0;
      bubble_ID_EX  = 1'b0;
      bubble_EX_MEM = 1'b0;
      bubble_MEM_WB = 1'b0;
      md_busy       = 1'b0;
      md_done       = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= MD_IDLE;
      md_cnt_q     <= '0;
      flush_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      md_cnt_q     <= md_cnt_d;
      flush_pend_q <= flush_pend_d;
    end
  end

endmodule

// File: tb/tb_stall_ctrl.sv
// Directed self-checking bench for stall_ctrl with default MUL_CYCLES=3, DIV_CYCLES=32.
module tb_stall_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] raddr_1_ID, raddr_2_ID, waddr_EX;
  logic       re_1_ID, re_2_ID, ReadMem_EX;
  logic       md_start_EX, md_is_div_EX, branch_taken_ID, mem_busy_MEM;
  logic       hold_PC, hold_IF_ID, hold_ID_EX, hold_EX_MEM;
  logic       flush_IF_ID, bubble_ID_EX, bubble_EX_MEM, bubble_MEM_WB;
  logic       md_busy, md_done;

  int n_cmp = 0;
  int n_err = 0;

  // Bit order: hold_PC hold_IF_ID hold_ID_EX hold_EX_MEM flush_IF_ID
  //            bubble_ID_EX bubble_EX_MEM bubble_MEM_WB md_busy md_done
  localparam logic [9:0] P_NONE    = 10'b0000000000;
  localparam logic [9:0] P_MD      = 10'b1110001010;
  localparam logic [9:0] P_MD_DONE = 10'b1110001011;
  localparam logic [9:0] P_MEM     = 10'b1111000100;
  localparam logic [9:0] P_MEM_RUN = 10'b1111000110;
  localparam logic [9:0] P_LU      = 10'b1100010000;
  localparam logic [9:0] P_FLUSH   = 10'b0000100000;

  logic [9:0] outs;
  assign outs = {hold_PC, hold_IF_ID, hold_ID_EX, hold_EX_MEM, flush_IF_ID,
                 bubble_ID_EX, bubble_EX_MEM, bubble_MEM_WB, md_busy, md_done};

  stall_ctrl dut (
    .clk             (clk),
    .rst             (rst),
    .raddr_1_ID      (raddr_1_ID),
    .raddr_2_ID      (raddr_2_ID),
    .re_1_ID         (re_1_ID),
    .re_2_ID         (re_2_ID),
    .ReadMem_EX      (ReadMem_EX),
    .waddr_EX        (waddr_EX),
    .md_start_EX     (md_start_EX),
    .md_is_div_EX    (md_is_div_EX),
    .branch_taken_ID (branch_taken_ID),
    .mem_busy_MEM    (mem_busy_MEM),
    .hold_PC         (hold_PC),
    .hold_IF_ID      (hold_IF_ID),
    .hold_ID_EX      (hold_ID_EX),
    .hold_EX_MEM     (hold_EX_MEM),
    .flush_IF_ID     (flush_IF_ID),
    .bubble_ID_EX    (bubble_ID_EX),
    .bubble_EX_MEM   (bubble_EX_MEM),
    .bubble_MEM_WB   (bubble_MEM_WB),
    .md_busy         (md_busy),
    .md_done         (md_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [9:0] exp);
    n_cmp++;
    assert (outs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, outs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    raddr_1_ID = '0; raddr_2_ID = '0; waddr_EX = '0;
    re_1_ID = 1'b0; re_2_ID = 1'b0; ReadMem_EX = 1'b0;
    md_start_EX = 1'b0; md_is_div_EX = 1'b0;
    branch_taken_ID = 1'b0; mem_busy_MEM = 1'b0;
  endtask

  initial begin
    logic [9:0] exp;

    // Reset with every stimulus active: all outputs forced low.
    clear_inputs();
    rst = 1'b1;
    md_start_EX = 1'b1; mem_busy_MEM = 1'b1; branch_taken_ID = 1'b1;
    ReadMem_EX = 1'b1; waddr_EX = 5'd5; re_1_ID = 1'b1; raddr_1_ID = 5'd5;
    #3 check("reset_outputs_zero", P_NONE);
    #10 clear_inputs();
    @(negedge clk) rst = 1'b0;
    next_cycle(); #1 check("idle_after_reset", P_NONE);

    // Load-use through source 1, then release once EX holds the bubble.
    next_cycle(); ReadMem_EX = 1'b1; waddr_EX = 5'd5; re_1_ID = 1'b1; raddr_1_ID = 5'd5;
    #1 check("lu_src1", P_LU);
    next_cycle(); ReadMem_EX = 1'b0;
    #1 check("lu_one_cycle", P_NONE);
    next_cycle(); ReadMem_EX = 1'b1; waddr_EX = 5'd0; raddr_1_ID = 5'd0;
    #1 check("lu_waddr_zero", P_NONE);
    next_cycle(); waddr_EX = 5'd7; re_1_ID = 1'b0; raddr_1_ID = 5'd7; re_2_ID = 1'b1; raddr_2_ID = 5'd7;
    #1 check("lu_src2", P_LU);
    next_cycle(); re_2_ID = 1'b0;
    #1 check("lu_re_gated", P_NONE);
    next_cycle(); re_1_ID = 1'b1; raddr_1_ID = 5'd6;
    #1 check("lu_addr_mismatch", P_NONE);

    // Branch during a load-use stall: deferred flush on the next free cycle.
    next_cycle(); raddr_1_ID = 5'd7; branch_taken_ID = 1'b1;
    #1 check("branch_in_lu", P_LU);
    next_cycle(); ReadMem_EX = 1'b0; re_1_ID = 1'b0; branch_taken_ID = 1'b0;
    #1 check("branch_pend_flush", P_FLUSH);
    next_cycle();
    #1 check("branch_pend_cleared", P_NONE);

    // Branch with no hold flushes immediately.
    next_cycle(); branch_taken_ID = 1'b1;
    #1 check("branch_direct", P_FLUSH);
    next_cycle(); branch_taken_ID = 1'b0;
    #1 check("branch_direct_done", P_NONE);

    // Memory stall while idle, with a branch deferred behind it.
    next_cycle(); mem_busy_MEM = 1'b1; branch_taken_ID = 1'b1;
    #1 check("mem_idle_branch", P_MEM);
    next_cycle(); mem_busy_MEM = 1'b0; branch_taken_ID = 1'b0;
    #1 check("mem_pend_flush", P_FLUSH);
    next_cycle();
    #1 check("mem_pend_cleared", P_NONE);

    // Multiply: three stall cycles, done on the third.
    next_cycle(); md_start_EX = 1'b1; md_is_div_EX = 1'b0;
    #1 check("mul_c1", P_MD);
    next_cycle(); md_start_EX = 1'b0;
    #1 check("mul_c2", P_MD);
    next_cycle();
    #1 check("mul_c3_done", P_MD_DONE);
    next_cycle();
    #1 check("mul_idle", P_NONE);

    // Divide with two memory-stall cycles at stall cycles 11 and 12: 34 cycles total.
    next_cycle(); md_start_EX = 1'b1; md_is_div_EX = 1'b1;
    #1 check("divmem_c1", P_MD);
    for (int c = 2; c <= 35; c++) begin
      next_cycle(); md_start_EX = 1'b0; mem_busy_MEM = (c == 11) || (c == 12);
      if (c == 11 || c == 12) exp = P_MEM_RUN;
      else if (c == 34)       exp = P_MD_DONE;
      else if (c == 35)       exp = P_NONE;
      else                    exp = P_MD;
      #1 check($sformatf("divmem_c%0d", c), exp);
    end
    mem_busy_MEM = 1'b0;

    // Asynchronous reset at divide cycle 10 aborts without md_done.
    next_cycle(); md_start_EX = 1'b1; md_is_div_EX = 1'b1;
    #1 check("divrst_c1", P_MD);
    for (int c = 2; c <= 10; c++) begin
      next_cycle(); md_start_EX = 1'b0;
      #1 check($sformatf("divrst_c%0d", c), P_MD);
    end
    #2 rst = 1'b1;
    #1 check("rst_async_zero", P_NONE);
    next_cycle();
    #1 check("rst_held_zero", P_NONE);
    @(negedge clk) rst = 1'b0;
    next_cycle();
    #1 check("post_rst_idle", P_NONE);

    // Fresh divide after reset counts a full 32 cycles.
    next_cycle(); md_start_EX = 1'b1; md_is_div_EX = 1'b1;
    #1 check("divfresh_c1", P_MD);
    for (int c = 2; c <= 33; c++) begin
      next_cycle(); md_start_EX = 1'b0;
      exp = (c == 32) ? P_MD_DONE : (c == 33) ? P_NONE : P_MD;
      #1 check($sformatf("divfresh_c%0d", c), exp);
    end

    // md_start held for 40 cycles: one run, then a new run from the first idle cycle.
    for (int c = 1; c <= 65; c++) begin
      next_cycle(); md_start_EX = (c <= 40); md_is_div_EX = 1'b1;
      if (c == 32 || c == 64) exp = P_MD_DONE;
      else if (c == 65)       exp = P_NONE;
      else                    exp = P_MD;
      #1 check($sformatf("divheld_c%0d", c), exp);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
